// File: rtl/axi_core_bridge.sv
// Bridges a simple single-beat core request port onto AXI4 read/write channels.
// One transaction in flight at a time; sub-word accesses are lane-aligned here.
`timescale 1ns/1ps
module axi_core_bridge #(
  parameter int W_ADR  = 32,
  parameter int W_DATA = 32,
  parameter int W_ID   = 4,
  parameter int ID     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  output logic              core_req_ack,
  input  logic              core_cmd,
  input  logic [1:0]        core_width,
  input  logic [W_ADR-1:0]  core_addr,
  input  logic [W_DATA-1:0] core_wdata,
  output logic [W_DATA-1:0] core_rdata,
  output logic [1:0]        core_resp,
  output logic              awvalid,
  output logic [W_ID-1:0]   awid,
  output logic [W_ADR-1:0]  awaddr,
  output logic [2:0]        awsize,
  output logic [7:0]        awlen,
  input  logic              awready,
  output logic              wvalid,
  output logic [W_DATA-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [W_ID-1:0]   bid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              arvalid,
  output logic [W_ID-1:0]   arid,
  output logic [W_ADR-1:0]  araddr,
  output logic [1:0]        arburst,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [W_ID-1:0]   rid,
  input  logic [W_DATA-1:0] rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  output logic              rready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR
  } state_t;

  localparam logic [W_ID-1:0] IdC = W_ID'(ID);

  state_t             state_q, state_d;
  logic [1:0]         width_q;
  logic [W_ADR-1:0]   addr_q;
  logic [W_DATA-1:0]  wdata_q;
  logic [3:0]         wstrb_q;
  logic               fields_q;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [1:0]         resp_q, resp_d;
  logic [W_DATA-1:0]  rdata_q;
  logic               accept, aligned_accept, rd_cap;
  logic               unused_in;

  assign unused_in = ^{rid, bid, rlast};

  function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] off);
    case (w)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] w, input logic [1:0] off);
    logic [3:0] base;
    case (w)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane_strb = base << off;
  endfunction

  // Bring the addressed lane down to bit 0 and zero-extend to the access width.
  function automatic logic [W_DATA-1:0] align_rdata(input logic [W_DATA-1:0] d,
                                                    input logic [1:0] off,
                                                    input logic [1:0] w);
    logic [W_DATA-1:0] sh;
    sh = d >> {off, 3'b000};
    case (w)
      2'd0:    align_rdata = {{(W_DATA-8){1'b0}}, sh[7:0]};
      2'd1:    align_rdata = {{(W_DATA-16){1'b0}}, sh[15:0]};
      default: align_rdata = sh;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    resp_d         = 2'b00;
    accept         = 1'b0;
    aligned_accept = 1'b0;
    rd_cap         = 1'b0;
    core_req_ack   = (state_q == IDLE);
    arvalid        = (state_q == RD_ADDR);
    rready         = (state_q == RD_DATA);
    awvalid        = (state_q == WR_REQ) && !aw_done_q;
    wvalid         = (state_q == WR_REQ) && !w_done_q;
    bready         = (state_q == WR_RESP);
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (core_req) begin
          accept = 1'b1;
          if (is_misaligned(core_width, core_addr[1:0])) begin
            state_d = ERR;
            resp_d  = 2'b10;
          end else begin
            aligned_accept = 1'b1;
            state_d = core_cmd ? WR_REQ : RD_ADDR;
          end
        end
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        if (rvalid) begin
          rd_cap  = 1'b1;
          resp_d  = (rresp == 2'b00) ? 2'b01 : 2'b10;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // The two channels may complete in any order, or together.
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          resp_d  = (bresp == 2'b00) ? 2'b01 : 2'b10;
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
      width_q   <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'd0;
      fields_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
      if (rd_cap) rdata_q <= align_rdata(rdata, addr_q[1:0], width_q);
      if (accept) begin
        width_q <= core_width;
        addr_q  <= core_addr;
        wdata_q <= core_wdata << {core_addr[1:0], 3'b000};
        wstrb_q <= lane_strb(core_width, core_addr[1:0]);
      end
      if (aligned_accept) fields_q <= 1'b1;
    end
  end

  // Constant-valued fields stay at zero until the first real transaction.
  assign awid       = fields_q ? IdC : '0;
  assign arid       = fields_q ? IdC : '0;
  assign arburst    = {1'b0, fields_q};
  assign wlast      = fields_q;
  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign awsize     = {1'b0, width_q};
  assign arsize     = {1'b0, width_q};
  assign awlen      = 8'd0;
  assign arlen      = 8'd0;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign core_resp  = resp_q;
  assign core_rdata = rdata_q;

endmodule

// File: doc/axi_core_bridge.md
AXI_CORE_BRIDGE -- requirements
Module: axi_core_bridge

Interface
REQ-001 Parameters SHALL be W_ADR=32 (address width), W_DATA=32 (data width, fixed), W_ID=4 (ID width), ID=0 (constant transaction ID).
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 core_req  in  1  core request valid.
REQ-005 core_req_ack  out  1  request accepted this cycle.
REQ-006 core_cmd  in  1  0=read, 1=write.
REQ-007 core_width  in  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 core_addr  in  W_ADR  byte address.
REQ-009 core_wdata  in  32  write data, LSB-aligned.
REQ-010 core_rdata  out  32  read data, LSB-aligned, zero-extended.
REQ-011 core_resp  out  2  00=idle, 01=ok, 10=error; one-cycle pulse.
REQ-012 AW channel: awvalid out 1, awid out W_ID, awaddr out W_ADR, awsize out 3, awlen out 8, awready in 1.
REQ-013 W channel: wvalid out 1, wdata out 32, wstrb out 4, wlast out 1, wready in 1.
REQ-014 B channel: bvalid in 1, bid in W_ID, bresp in 2, bready out 1.
REQ-015 AR channel: arvalid out 1, arid out W_ID, araddr out W_ADR, arburst out 2, arsize out 3, arlen out 8, arready in 1.
REQ-016 R channel: rvalid in 1, rid in W_ID, rdata in 32, rlast in 1, rresp in 2, rready out 1.

Function
REQ-017 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR; at most one transaction SHALL be outstanding.
REQ-018 core_req_ack SHALL be 1 exactly when the state is IDLE; a request SHALL be accepted on core_req & core_req_ack, latching cmd, width, addr and wdata.
REQ-019 An accepted request SHALL be misaligned when width=1 & addr[0]=1, when width=2 & addr[1:0]!=0, or when width=3.
REQ-020 A misaligned request SHALL go to ERR, issue no AXI valid, and pulse core_resp=10 in the following cycle, then return to IDLE.
REQ-021 An aligned read SHALL go to RD_ADDR with arvalid=1 in the cycle after acceptance.
REQ-022 arvalid SHALL hold until arready; the FSM SHALL then move to RD_DATA with rready=1.
REQ-023 An aligned write SHALL go to WR_REQ with awvalid=1 and wvalid=1 both asserted in the cycle after acceptance.
REQ-024 In WR_REQ, awvalid and wvalid SHALL each drop independently after their own handshake.
REQ-025 The FSM SHALL leave WR_REQ for WR_RESP (bready=1) once both handshakes are done, including when both complete in the same cycle or in either order.
REQ-026 Address-channel fields SHALL be: araddr/awaddr=latched addr, arsize/awsize={0,width}, arlen/awlen=0, arburst=01, arid/awid=ID, wlast=1.
REQ-027 wdata SHALL be core_wdata << (8*addr[1:0]); wstrb SHALL be {0001,0011,1111}[width] << addr[1:0].
REQ-028 On rvalid & rready, core_rdata SHALL be rdata >> (8*addr[1:0]), masked to 8/16/32 bits per width.
REQ-029 On rvalid & rready, the FSM SHALL return to IDLE, and core_resp SHALL be 01 when rresp=00, else 10, registered one cycle after the handshake.
REQ-030 On bvalid & bready, the FSM SHALL return to IDLE, and core_resp SHALL be 01 when bresp=00, else 10, registered one cycle after the handshake.
REQ-031 rid, bid and rlast SHALL be ignored; rlast=0 SHALL NOT stall completion.
REQ-032 core_rdata SHALL hold its value until the next read completion.
REQ-033 Minimum read latency SHALL be 3 cycles from acceptance to core_resp, given arready=1 and rvalid one cycle after the AR handshake.

Reset
REQ-034 While rst_n=0, the outputs SHALL be: state IDLE, core_req_ack=1, core_resp=00, core_rdata=0, and all AXI valid/ready outputs (awvalid, wvalid, arvalid, bready, rready)=0.
REQ-035 While rst_n=0, the remaining AXI outputs SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abort it at once, produce no core_resp, and drop all valids asynchronously.

Verification
REQ-037 Word read at 0x100, memory returns 0xDEADBEEF with rresp=00 -> arsize=2, arlen=0; core_rdata=0xDEADBEEF; core_resp=01 for exactly one cycle.
REQ-038 Byte write 0xA5 at 0x103 -> wdata=0xA5000000, wstrb=1000, awsize=0; bresp=00 yields core_resp=01.
REQ-039 Halfword read at 0x102, rdata=0x1234ABCD -> core_rdata=0x00001234.
REQ-040 Write with wready held 0 for 3 cycles while awready=1 -> awvalid drops after 1 cycle, wvalid holds 4 cycles, bready is asserted only afterwards, and a single core_resp=01 is produced.
REQ-041 Halfword access at 0x101 -> no AXI valid ever rises, and core_resp=10 occurs in the cycle after acceptance.
REQ-042 Read with rresp=10 -> core_resp=10; rst_n pulsed during RD_DATA -> rready=0 immediately and no core_resp.
